// File: rtl/feed_pkg.sv
// Shared definitions for the market-data feed path: deframer state encoding,
// frame geometry, default marker/type bytes and field widths reused by the
// downstream feed handler.
package feed_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        BODY  = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int FRAME_LEN_CHK   = 9;
    localparam int FRAME_LEN_NOCHK = 8;

    localparam int TS_W   = 16;
    localparam int DATA_W = 32;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
    localparam logic [7:0] DEF_MSG_TYPE  = 8'h01;

    // Byte index of D0, the last byte captured while in BODY.
    localparam logic [2:0] LAST_BODY_IDX = 3'd7;

    // Saturating increment for 16-bit event counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/feed_idle_timer.sv
// Inter-byte idle timer for the deframer. Counts cycles without a valid byte
// while enabled and flags expiry on the cycle the count would reach TIMEOUT.
// A clear in that same cycle (a byte arriving) suppresses the expiry.
module feed_idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_r;
    logic          expired_s;

    // Expiry is decided combinationally so the FSM reacts on the same edge.
    always_comb begin
        if (enable && !clear && (count_r == LAST_COUNT)) begin
            expired_s = 1'b1;
        end else begin
            expired_s = 1'b0;
        end
    end

    assign expired = expired_s;

    // Idle counter: cleared by bytes, by being disabled, or on expiry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= {CW{1'b0}};
        end else if (clear || !enable || expired_s) begin
            count_r <= {CW{1'b0}};
        end else begin
            count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/feed_deframer.sv
// Byte-stream deframer feeding the timestamp-filtering feed handler.
// Frame: SYNC, TYPE, TS_HI, TS_LO, D3, D2, D1, D0 [, CHK].
// Build option: define FEED_DEFRAMER_CHKSUM_EN to append and check the XOR
// checksum byte (9-byte frames); otherwise frames are 8 bytes and only the
// idle timeout reports errors.
module feed_deframer
    import feed_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
    parameter logic [7:0] MSG_TYPE  = DEF_MSG_TYPE,
    parameter int         TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [7:0]        s_byte,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [TS_W-1:0]   out_ts,
    output logic              err_pulse,
    output logic [15:0]       err_count
);

    state_t            state_r;
    logic [2:0]        idx_r;
    logic [7:0]        type_r;
    logic [TS_W-1:0]   ts_sh_r;
    logic [DATA_W-1:0] data_sh_r;
`ifdef FEED_DEFRAMER_CHKSUM_EN
    logic [7:0]        xor_r;
`endif

    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic [TS_W-1:0]   out_ts_r;
    logic              err_pulse_r;
    logic [15:0]       err_count_r;

    logic              in_frame_s;
    logic              timer_expired_s;

    // The timer only runs while a frame is being assembled.
    always_comb begin
        if (state_r == HUNT) begin
            in_frame_s = 1'b0;
        end else begin
            in_frame_s = 1'b1;
        end
    end

    feed_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (s_valid),
        .enable  (in_frame_s),
        .expired (timer_expired_s)
    );

    // Framing FSM: hunt for sync, capture body bytes, evaluate, emit pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= HUNT;
            idx_r       <= 3'd0;
            type_r      <= 8'h00;
            ts_sh_r     <= {TS_W{1'b0}};
            data_sh_r   <= {DATA_W{1'b0}};
`ifdef FEED_DEFRAMER_CHKSUM_EN
            xor_r       <= 8'h00;
`endif
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
            out_ts_r    <= {TS_W{1'b0}};
            err_pulse_r <= 1'b0;
            err_count_r <= 16'h0000;
        end else begin
            out_valid_r <= 1'b0;
            err_pulse_r <= 1'b0;
            case (state_r)
                HUNT: begin
                    if (s_valid && (s_byte == SYNC_BYTE)) begin
                        state_r <= BODY;
                        idx_r   <= 3'd1;
`ifdef FEED_DEFRAMER_CHKSUM_EN
                        xor_r   <= 8'h00;
`endif
                    end
                end

                BODY: begin
                    if (s_valid) begin
`ifdef FEED_DEFRAMER_CHKSUM_EN
                        xor_r <= xor_r ^ s_byte;
`endif
                        case (idx_r)
                            3'd1:    type_r    <= s_byte;
                            3'd2,
                            3'd3:    ts_sh_r   <= {ts_sh_r[TS_W-9:0], s_byte};
                            default: data_sh_r <= {data_sh_r[DATA_W-9:0], s_byte};
                        endcase
                        if (idx_r == LAST_BODY_IDX) begin
`ifdef FEED_DEFRAMER_CHKSUM_EN
                            state_r <= CHECK;
`else
                            // No checksum: the frame is judged on D0 itself.
                            state_r <= HUNT;
                            if (type_r == MSG_TYPE) begin
                                out_valid_r <= 1'b1;
                                out_data_r  <= {data_sh_r[DATA_W-9:0], s_byte};
                                out_ts_r    <= ts_sh_r;
                            end
`endif
                        end else begin
                            idx_r <= idx_r + 3'd1;
                        end
                    end else if (timer_expired_s) begin
                        state_r     <= HUNT;
                        err_pulse_r <= 1'b1;
                        err_count_r <= sat_inc16(err_count_r);
                    end
                end

                CHECK: begin
`ifdef FEED_DEFRAMER_CHKSUM_EN
                    if (s_valid) begin
                        state_r <= HUNT;
                        if (s_byte != xor_r) begin
                            err_pulse_r <= 1'b1;
                            err_count_r <= sat_inc16(err_count_r);
                        end else if (type_r == MSG_TYPE) begin
                            out_valid_r <= 1'b1;
                            out_data_r  <= data_sh_r;
                            out_ts_r    <= ts_sh_r;
                        end
                    end else if (timer_expired_s) begin
                        state_r     <= HUNT;
                        err_pulse_r <= 1'b1;
                        err_count_r <= sat_inc16(err_count_r);
                    end
`else
                    // Unreachable without the checksum byte; recover to hunt.
                    state_r <= HUNT;
`endif
                end

                default: begin
                    state_r <= HUNT;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_ts    = out_ts_r;
    assign err_pulse = err_pulse_r;
    assign err_count = err_count_r;

endmodule

// File: doc/feed_deframer.md
# feed_deframer

Byte-stream deframer directly upstream of the timestamp-filtering feed handler. It hunts for a sync byte, assembles a fixed-length market-data frame (type, 16-bit timestamp, 32-bit payload, optional checksum) and emits one registered (valid, data, ts) beat per good frame. Its outputs connect one-to-one to the feed handler's `in_valid` / `in_data` / `in_ts`. It also reports framing errors.

## Interface

**Parameters**
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `MSG_TYPE`, default 8'h01: only frames of this type are forwarded.
- `TIMEOUT`, default 16: maximum idle cycles allowed between bytes inside a frame.

**Ports**
- `clk` input 1: single clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-low reset.
- `s_valid` input 1: `s_byte` is valid this cycle; gaps are allowed.
- `s_byte` input 8: stream byte.
- `out_valid` output 1: one-cycle pulse per accepted frame.
- `out_data` output 32: frame payload, big-endian assembled.
- `out_ts` output 16: frame timestamp, big-endian assembled.
- `err_pulse` output 1: one-cycle pulse on checksum error or timeout.
- `err_count` output 16: saturating count of `err_pulse` events.

## Operation

**Frame layout:** SYNC, TYPE, TS_HI, TS_LO, D3, D2, D1, D0, then CHK (when the checksum is compiled in).
- D3 is the MSB.
- CHK is the XOR of TYPE through D0.

**States**
- HUNT:
  - `s_valid` with `s_byte == SYNC_BYTE` → BODY, byte index 1.
  - Any other byte is discarded silently.
- BODY: capture bytes 1..7 into shift registers and update the running XOR.
  - After D0 → CHECK if the checksum is compiled in.
  - Otherwise → HUNT and evaluate the frame immediately.
- CHECK: the next valid byte is compared against the running XOR, then → HUNT.

**Frame evaluation on the last byte**
- Checksum mismatch: `err_pulse`; the frame is dropped.
- Checksum good but TYPE ≠ `MSG_TYPE`: dropped silently, no error.
- Otherwise: `out_valid` pulses and `out_data` / `out_ts` load.

**Other rules**
- A sync byte value appearing inside BODY/CHECK is treated as data; there is no resync mid-frame.
- **Timeout:** an idle counter clears on every valid byte and increments each cycle without one while in BODY/CHECK.
  - When it reaches `TIMEOUT` → `err_pulse`, discard the partial frame, → HUNT.
  - The counter is held at 0 in HUNT.
- `err_count` increments on every `err_pulse` and saturates at 16'hFFFF.
- `out_data` / `out_ts` hold their last accepted values between pulses.
- There is no backpressure; every valid byte is consumed.

## Timing

- **Reset values** (`reset == 0` at a clock edge):
  - state HUNT
  - `out_valid` 0, `out_data` 0, `out_ts` 0
  - `err_pulse` 0, `err_count` 0
  - idle counter 0, XOR accumulator 0
- **Reset mid-frame:** the partial frame is discarded and no pulse is emitted.
- **Latency:** `out_valid` / `err_pulse` assert in the cycle after the edge that accepts the final frame byte. They are high for exactly one cycle.
- **Back-to-back frames:** a SYNC may arrive in the cycle immediately after the last byte of the previous frame and is accepted. The sustained rate is one frame per 9 (or 8) valid cycles.
- **Timeout vs. byte arrival:** a byte arriving in the same cycle the counter would reach `TIMEOUT` wins; the counter clears and no error is raised.
- `out_valid` and `err_pulse` are never high in the same cycle.

## Configuration

- `FEED_DEFRAMER_CHKSUM_EN` defined:
  - Frames are 9 bytes; the CHECK state exists.
  - Mismatches raise `err_pulse`.
- Not defined:
  - Frames are 8 bytes; the CHECK state and XOR logic are removed.
  - Only timeouts raise `err_pulse`.

## Structure

- **Shared package `feed_pkg`:**
  - state enum (HUNT, BODY, CHECK)
  - frame-length localparams (`FRAME_LEN_CHK = 9`, `FRAME_LEN_NOCHK = 8`)
  - default `SYNC_BYTE` / `MSG_TYPE` constants
  - feed handler reuses the ts/data width constants (16/32)
- **Sub-module `feed_idle_timer`:** the idle counter with clear/enable inputs and an expired output. All remaining logic is flat.

## Test plan

1. **Good frame:** `A5 01 12 34 DE AD BE EF 05`, contiguous → one `out_valid`, `out_ts == 16'h1234`, `out_data == 32'hDEADBEEF`, `err_pulse` stays 0.
2. **Bad checksum:** same frame with CHK `06` → no `out_valid`, one `err_pulse`, `err_count == 1`.
3. **Type filter:** TYPE `02`, valid CHK `06` → no `out_valid`, no `err_pulse`.
4. **Timeout:** `A5 01 12` then 16 idle cycles → `err_pulse` once, state HUNT. A good frame sent afterwards is accepted.
5. **Hunt and back-to-back:** `00 FF` garbage followed by two good frames, the second with ts `1235` and no gap → exactly two `out_valid` pulses, 9 cycles apart.
6. **Reset mid-frame:** reset asserted after byte 5, then the good frame resent → all outputs 0 during reset; exactly one `out_valid` after release. Also run the bench with `FEED_DEFRAMER_CHKSUM_EN` undefined, using the 8-byte form of scenario 1.
